ahb_lite_interconnect: RTL and testbench
========================================

AHB_LITE_INTERCONNECT -- requirements
Module: ahb_lite_interconnect

Interface
REQ-001 SHALL provide parameter NUM_SLAVES, default 10, number of decoded slave ports (1..16).
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 1024, wait-state limit per data phase; 0 disables timeout.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: HCLK, HRESETn.
REQ-004 HCLK  in  1  system bus clock.
REQ-005 HRESETn  in  1  asynchronous active-low reset.
REQ-006 HADDR  in  32  master address.
REQ-007 HTRANS  in  2  master transfer type.
REQ-008 HSEL  out  NUM_SLAVES  one-hot address-phase slave select (combinational).
REQ-009 HRDATA_S  in  32*NUM_SLAVES  slave read data, slave i in bits [32i+31:32i].
REQ-010 HREADYOUT_S  in  NUM_SLAVES  slave ready.
REQ-011 HRESP_S  in  NUM_SLAVES  slave error response.
REQ-012 HRDATA  out  32  muxed read data to master.
REQ-013 HREADY  out  1  muxed ready to master and all slaves.
REQ-014 HRESP  out  1  muxed response to master.
REQ-015 TIMEOUT_IRQ  out  1  sticky timeout flag.
REQ-016 TIMEOUT_CLR  in  1  synchronous clear of TIMEOUT_IRQ.

Function
REQ-017 Decode SHALL compare HADDR[31:24] against package table SLAVE_BASE[i]; match on slave i drives HSEL[i]=1; no match is "unmapped", HSEL all zero.
REQ-018 Data-phase owner register (slave index, or UNMAPPED, or NONE) SHALL load from the decode only when HREADY=1.
REQ-019 Owner NONE (after reset): HREADY=1, HRESP=0, HRDATA=0.
REQ-020 Owner slave i, state NORMAL: HRDATA=HRDATA_S[i], HREADY=HREADYOUT_S[i], HRESP=HRESP_S[i].
REQ-021 FSM states: NORMAL, ERR1, ERR2.
REQ-022 Address phase with HTRANS[1]=1 to unmapped address while HREADY=1 -> next cycle ERR1.
REQ-023 ERR1: HREADY=0, HRESP=1, HRDATA=32'hDEADBEEF; next ERR2.
REQ-024 ERR2: HREADY=1, HRESP=1, HRDATA=32'hDEADBEEF; next NORMAL (or ERR1 if a new unmapped NONSEQ/SEQ is accepted this cycle).
REQ-025 IDLE/BUSY transfer to unmapped address SHALL complete zero-wait OKAY (HREADY=1, HRESP=0, HRDATA=DEADBEEF).
REQ-026 Wait counter (width clog2(TIMEOUT_CYCLES+1)) SHALL clear whenever HREADY=1 and increment each cycle owner is a slave with HREADYOUT_S=0.
REQ-027 Counter reaching TIMEOUT_CYCLES (non-zero) SHALL force ERR1 next cycle, set TIMEOUT_IRQ, ignore slave outputs until ERR2 completes.
REQ-028 Late slave HREADYOUT/HRESP during forced ERR1/ERR2 SHALL be ignored.
REQ-029 TIMEOUT_CLR and a new timeout in the same cycle: set wins.
REQ-030 Address inputs SHALL be ignored while HREADY=0.

Reset
REQ-031 On HRESETn=0: owner=NONE, FSM=NORMAL, counter=0, TIMEOUT_IRQ=0, immediately and asynchronously, including mid-ERR1/ERR2 or mid-wait.
REQ-032 Reset deassertion SHALL be used as-is; synchronisation is the system's responsibility.

Structure
REQ-033 Package ahb_ic_pkg SHALL hold SLAVE_BASE table, HTRANS encodings, FSM state typedef, DEFAULT_RDATA=32'hDEADBEEF.
REQ-034 Default-slave/timeout FSM SHALL be sub-module ahb_ic_default_slave; decode and mux remain in the top.

Verification
REQ-035 NONSEQ read to slave 0 base, HREADYOUT_S[0]=1, HRDATA_S0=32'h12345678 -> HSEL[0]=1; next cycle HRDATA=32'h12345678, HREADY=1, HRESP=0.
REQ-036 NONSEQ to unmapped 32'hFF000000 -> cycle+1 HREADY=0,HRESP=1; cycle+2 HREADY=1,HRESP=1,HRDATA=DEADBEEF; IDLE to same address -> OKAY zero-wait.
REQ-037 TIMEOUT_CYCLES=4, slave 1 holds HREADYOUT low -> 4 waits, then ERR1, ERR2, TIMEOUT_IRQ=1; TIMEOUT_CLR pulse -> 0.
REQ-038 Slave 4 inserts 2 wait states then HRESP_S=1 two-cycle error -> passed through unchanged, no timeout.
REQ-039 Back-to-back: unmapped NONSEQ then slave 0 NONSEQ accepted in ERR2 -> slave 0 data phase follows cleanly.
REQ-040 HRESETn asserted during ERR1 -> same cycle HREADY=1, HRESP=0, HRDATA=0, TIMEOUT_IRQ=0.

Source files
------------

// File: rtl/ahb_ic_pkg.sv
// Shared definitions for the AHB-Lite interconnect: address map, transfer
// encodings, default-slave FSM states and data-phase owner bookkeeping.
package ahb_ic_pkg;

    // Entry i is matched against HADDR[31:24]; only the first NUM_SLAVES entries are live.
    localparam logic [15:0][7:0] SLAVE_BASE = {
        8'hF0, 8'hE0, 8'hD0, 8'hC0, 8'hB0, 8'hA0, 8'h90, 8'h80,
        8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10, 8'h00
    };

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [31:0] DEFAULT_RDATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_ERR1   = 2'd1,
        ST_ERR2   = 2'd2
    } ds_state_t;

    typedef enum logic [1:0] {
        OWN_NONE     = 2'd0,
        OWN_SLAVE    = 2'd1,
        OWN_UNMAPPED = 2'd2
    } owner_kind_t;

    typedef struct packed {
        owner_kind_t kind;
        logic [3:0]  idx;
    } owner_t;

    function automatic logic htrans_active(input logic [1:0] t);
        case (t)
            HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_ic_default_slave.sv
// Default slave: two-cycle ERROR response for unmapped transfers and for
// data phases that exceed the wait-state limit, plus the sticky timeout flag.
module ahb_ic_default_slave
    import ahb_ic_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      hready,
    input  logic      err_accept,
    input  logic      owner_slave,
    input  logic      slave_ready,
    input  logic      timeout_clr,
    output ds_state_t state,
    output logic      timeout_irq
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(TIMEOUT_CYCLES);
    localparam logic [CW:0] ONE   = {{CW{1'b0}}, 1'b1};

    logic [CW-1:0] wait_cnt;
    logic [CW:0]   cnt_inc;
    logic          stall;
    logic          hit;
    ds_state_t     state_next;

    // Slave outputs only count while NORMAL; once an error is forced they are ignored.
    assign stall   = (state == ST_NORMAL) && owner_slave && !slave_ready;
    assign cnt_inc = {1'b0, wait_cnt} + ONE;
    assign hit     = (TIMEOUT_CYCLES != 0) && stall && (cnt_inc == LIMIT);

    always_comb begin
        state_next = state;
        case (state)
            ST_NORMAL: if (hit || err_accept) state_next = ST_ERR1;
            ST_ERR1:   state_next = ST_ERR2;
            ST_ERR2:   state_next = err_accept ? ST_ERR1 : ST_NORMAL;
            default:   state_next = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_NORMAL;
            wait_cnt    <= '0;
            timeout_irq <= 1'b0;
        end else begin
            state <= state_next;
            if (hready) begin
                wait_cnt <= '0;
            end else if (stall) begin
                wait_cnt <= cnt_inc[CW-1:0];
            end
            if (hit) begin
                timeout_irq <= 1'b1;
            end else if (timeout_clr) begin
                timeout_irq <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ahb_lite_interconnect.sv
// Single-master AHB-Lite interconnect: address decode, data-phase owner
// tracking and response multiplexing, with a default slave for errors/timeouts.
module ahb_lite_interconnect
    import ahb_ic_pkg::*;
#(
    parameter int NUM_SLAVES     = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    output logic [NUM_SLAVES-1:0]   HSEL,
    input  logic [32*NUM_SLAVES-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]   HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]   HRESP_S,
    output logic [31:0]             HRDATA,
    output logic                    HREADY,
    output logic                    HRESP,
    output logic                    TIMEOUT_IRQ,
    input  logic                    TIMEOUT_CLR
);

    logic        dec_hit;
    logic [3:0]  dec_idx;
    owner_t      owner;
    logic [31:0] sl_rdata;
    logic        sl_ready;
    logic        sl_resp;
    logic        owner_slave;
    logic        err_accept;
    ds_state_t   err_state;
    logic        unused_addr;

    assign unused_addr = ^HADDR[23:0];

    always_comb begin
        HSEL    = '0;
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!dec_hit && (HADDR[31:24] == SLAVE_BASE[i])) begin
                HSEL[i] = 1'b1;
                dec_hit = 1'b1;
                dec_idx = 4'(i);
            end
        end
    end

    // The owner only advances when the current data phase completes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner <= '{kind: OWN_NONE, idx: 4'd0};
        end else if (HREADY) begin
            if (dec_hit) begin
                owner <= '{kind: OWN_SLAVE, idx: dec_idx};
            end else begin
                owner <= '{kind: OWN_UNMAPPED, idx: 4'd0};
            end
        end
    end

    always_comb begin
        sl_rdata = '0;
        sl_ready = 1'b1;
        sl_resp  = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (owner.idx == 4'(i)) begin
                sl_rdata = HRDATA_S[32*i +: 32];
                sl_ready = HREADYOUT_S[i];
                sl_resp  = HRESP_S[i];
            end
        end
    end

    assign owner_slave = (owner.kind == OWN_SLAVE);

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        if (err_state != ST_NORMAL) begin
            HREADY = (err_state == ST_ERR2);
            HRESP  = 1'b1;
            HRDATA = DEFAULT_RDATA;
        end else begin
            case (owner.kind)
                OWN_SLAVE: begin
                    HREADY = sl_ready;
                    HRESP  = sl_resp;
                    HRDATA = sl_rdata;
                end
                // IDLE/BUSY to an unmapped address still completes OKAY.
                OWN_UNMAPPED: HRDATA = DEFAULT_RDATA;
                default: ;
            endcase
        end
    end

    assign err_accept = HREADY && !dec_hit && htrans_active(HTRANS);

    ahb_ic_default_slave #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_default_slave (
        .clk         (HCLK),
        .rst_n       (HRESETn),
        .hready      (HREADY),
        .err_accept  (err_accept),
        .owner_slave (owner_slave),
        .slave_ready (sl_ready),
        .timeout_clr (TIMEOUT_CLR),
        .state       (err_state),
        .timeout_irq (TIMEOUT_IRQ)
    );

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Directed bench for ahb_lite_interconnect: each cycle's expected
// {HREADY, HRESP, HRDATA, TIMEOUT_IRQ} is queued and checked at the falling edge.
module tb_ahb_lite_interconnect;
    import ahb_ic_pkg::*;

    localparam int NS = 10;
    localparam int TO = 4;

    logic                 hclk;
    logic                 hresetn;
    logic [31:0]          haddr;
    logic [1:0]           htrans;
    logic [NS-1:0]        hsel;
    logic [32*NS-1:0]     hrdata_s;
    logic [NS-1:0]        hreadyout_s;
    logic [NS-1:0]        hresp_s;
    logic [31:0]          hrdata;
    logic                 hready;
    logic                 hresp;
    logic                 timeout_irq;
    logic                 timeout_clr;

    int compared   = 0;
    int mismatched = 0;
    logic [34:0] exp_q[$];

    ahb_lite_interconnect #(
        .NUM_SLAVES    (NS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .HCLK        (hclk),
        .HRESETn     (hresetn),
        .HADDR       (haddr),
        .HTRANS      (htrans),
        .HSEL        (hsel),
        .HRDATA_S    (hrdata_s),
        .HREADYOUT_S (hreadyout_s),
        .HRESP_S     (hresp_s),
        .HRDATA      (hrdata),
        .HREADY      (hready),
        .HRESP       (hresp),
        .TIMEOUT_IRQ (timeout_irq),
        .TIMEOUT_CLR (timeout_clr)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    function automatic logic [34:0] e(input logic r, input logic rs,
                                      input logic [31:0] d, input logic irq);
        return {r, rs, d, irq};
    endfunction

    task automatic set_rdata(input int i, input logic [31:0] v);
        hrdata_s[32*i +: 32] = v;
    endtask

    task automatic compare_now(input string tag);
        logic [34:0] obs;
        logic [34:0] exp;
        obs = {hready, hresp, hrdata, timeout_irq};
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $error("FAIL %s: observed %h, no expectation queued", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                mismatched++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic check(input string tag);
        @(negedge hclk);
        compare_now(tag);
    endtask

    // Queue the expectation for the current cycle, check it, then advance.
    task automatic cyc(input string tag, input logic [34:0] v);
        exp_q.push_back(v);
        check(tag);
        @(posedge hclk);
        #1;
    endtask

    task automatic check_hsel(input string tag, input logic [NS-1:0] exp);
        #1;
        compared++;
        assert (hsel === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, hsel, exp);
        end
    endtask

    initial begin
        hresetn     = 1'b0;
        haddr       = '0;
        htrans      = HTRANS_IDLE;
        hrdata_s    = '0;
        hreadyout_s = '1;
        hresp_s     = '0;
        timeout_clr = 1'b0;
        set_rdata(0, 32'h12345678);
        set_rdata(1, 32'h11111111);
        set_rdata(4, 32'h44444444);

        exp_q.push_back(e(1'b1, 1'b0, 32'h0, 1'b0));
        check("reset");
        @(posedge hclk);
        #1;
        hresetn = 1'b1;

        // Plain read from slave 0, then idle to slave 1.
        haddr = 32'h0000_0000; htrans = HTRANS_NONSEQ;
        check_hsel("hsel_s0", 10'b00_0000_0001);
        cyc("a1_owner_none", e(1'b1, 1'b0, 32'h0, 1'b0));
        haddr = 32'h1000_0000; htrans = HTRANS_IDLE;
        check_hsel("hsel_s1", 10'b00_0000_0010);
        cyc("a2_s0_read", e(1'b1, 1'b0, 32'h12345678, 1'b0));
        haddr = 32'hA000_0000;
        check_hsel("hsel_a0_unmapped", 10'b0);
        haddr = 32'hFF00_0000; htrans = HTRANS_NONSEQ;
        check_hsel("hsel_ff_unmapped", 10'b0);
        cyc("a3_s1_idle", e(1'b1, 1'b0, 32'h11111111, 1'b0));

        // Unmapped NONSEQ -> ERR1/ERR2, then IDLE to the same address is OKAY.
        haddr = 32'h2000_0000; htrans = HTRANS_NONSEQ;
        cyc("b1_err1", e(1'b0, 1'b1, DEFAULT_RDATA, 1'b0));
        haddr = 32'hFF00_0000; htrans = HTRANS_IDLE;
        cyc("b2_err2", e(1'b1, 1'b1, DEFAULT_RDATA, 1'b0));
        haddr = 32'hFF00_0004; htrans = HTRANS_NONSEQ;
        cyc("b3_unmapped_idle_okay", e(1'b1, 1'b0, DEFAULT_RDATA, 1'b0));

        // Back-to-back: slave 0 NONSEQ accepted during ERR2.
        haddr = 32'h3000_0000; htrans = HTRANS_NONSEQ;
        cyc("c1_err1", e(1'b0, 1'b1, DEFAULT_RDATA, 1'b0));
        haddr = 32'h0000_0000; htrans = HTRANS_NONSEQ;
        set_rdata(0, 32'hCAFEF00D);
        cyc("c2_err2", e(1'b1, 1'b1, DEFAULT_RDATA, 1'b0));
        haddr = 32'h4000_0000; htrans = HTRANS_NONSEQ;
        hreadyout_s[4] = 1'b0;
        cyc("c3_s0_after_err", e(1'b1, 1'b0, 32'hCAFEF00D, 1'b0));

        // Slave 4: two waits then its own two-cycle error; unmapped address ignored while stalled.
        haddr = 32'hFF00_0000; htrans = HTRANS_NONSEQ;
        cyc("d1_s4_wait", e(1'b0, 1'b0, 32'h44444444, 1'b0));
        cyc("d2_s4_wait", e(1'b0, 1'b0, 32'h44444444, 1'b0));
        hresp_s[4] = 1'b1;
        cyc("d3_s4_err1", e(1'b0, 1'b1, 32'h44444444, 1'b0));
        hreadyout_s[4] = 1'b1;
        haddr = 32'h1000_0000; htrans = HTRANS_NONSEQ;
        cyc("d4_s4_err2", e(1'b1, 1'b1, 32'h44444444, 1'b0));

        // Slave 1 stalls: four waits, then forced ERR1/ERR2 with late slave outputs ignored.
        hresp_s[4] = 1'b0;
        hreadyout_s[1] = 1'b0;
        haddr = 32'h0000_0000; htrans = HTRANS_IDLE;
        for (int k = 0; k < TO; k++) begin
            cyc("e_s1_wait", e(1'b0, 1'b0, 32'h11111111, 1'b0));
        end
        hreadyout_s[1] = 1'b1;
        hresp_s[1] = 1'b1;
        cyc("e5_timeout_err1", e(1'b0, 1'b1, DEFAULT_RDATA, 1'b1));
        cyc("e6_timeout_err2", e(1'b1, 1'b1, DEFAULT_RDATA, 1'b1));
        hresp_s[1] = 1'b0;
        timeout_clr = 1'b1;
        cyc("e7_irq_before_clr", e(1'b1, 1'b0, 32'hCAFEF00D, 1'b1));
        timeout_clr = 1'b0;
        haddr = 32'h1000_0000; htrans = HTRANS_NONSEQ;
        hreadyout_s[1] = 1'b0;
        cyc("e8_irq_cleared", e(1'b1, 1'b0, 32'hCAFEF00D, 1'b0));

        // Second timeout with clear held high: set wins.
        timeout_clr = 1'b1;
        haddr = 32'h0000_0000; htrans = HTRANS_IDLE;
        for (int k = 0; k < TO; k++) begin
            cyc("f_s1_wait", e(1'b0, 1'b0, 32'h11111111, 1'b0));
        end
        timeout_clr = 1'b0;
        cyc("f5_set_wins", e(1'b0, 1'b1, DEFAULT_RDATA, 1'b1));
        hreadyout_s[1] = 1'b1;
        cyc("f6_err2", e(1'b1, 1'b1, DEFAULT_RDATA, 1'b1));

        // Asynchronous reset in the middle of ERR1.
        haddr = 32'hFF00_0000; htrans = HTRANS_NONSEQ;
        cyc("g1_s0", e(1'b1, 1'b0, 32'hCAFEF00D, 1'b1));
        haddr = 32'h0000_0000; htrans = HTRANS_IDLE;
        exp_q.push_back(e(1'b0, 1'b1, DEFAULT_RDATA, 1'b1));
        check("g2_err1");
        #2;
        hresetn = 1'b0;
        #1;
        exp_q.push_back(e(1'b1, 1'b0, 32'h0, 1'b0));
        compare_now("g2_async_reset");
        @(posedge hclk);
        #1;
        cyc("reset_hold", e(1'b1, 1'b0, 32'h0, 1'b0));
        hresetn = 1'b1;
        cyc("after_reset_none", e(1'b1, 1'b0, 32'h0, 1'b0));
        cyc("after_reset_s0", e(1'b1, 1'b0, 32'hCAFEF00D, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
